// File: rtl/convenc.sv
// K=7 (g0=133o, g1=171o) convolutional encoder with 1/2, 2/3, 3/4 puncturing.
// Define CONVENC_TAIL_EN to append 6 zero tail bits that terminate the trellis.
module convenc #(
   parameter int unsigned NBITS_W = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         coderate,
   input  logic [NBITS_W-1:0] nofbits,
   input  logic [7:0]         in_byte,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               enc_bit,
   output logic               enc_valid,
   input  logic               enc_ready,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StTail, StFlush} state_e;

`ifdef CONVENC_TAIL_EN
   localparam state_e StEnd = StTail;
`else
   localparam state_e StEnd = StFlush;
`endif

   state_e state_q, state_d;

   logic [5:0]         s_q, s_d;
   logic [7:0]         byte_q, byte_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [NBITS_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [NBITS_W-1:0] nofbits_q, nofbits_d;
   logic [1:0]         rate_q, rate_d;
   logic [1:0]         phase_q, phase_d;
   logic               sel_q, sel_d;
   logic               enc_bit_q, enc_bit_d;
   logic               enc_valid_q, enc_valid_d;
   logic               done_q, done_d;
`ifdef CONVENC_TAIL_EN
   logic [2:0]         tail_cnt_q, tail_cnt_d;
`endif

   logic slot_free, emit_step, emit_b, bit_last, advance;
   logic data_last, tail_last, period_last, keep_a, keep_b;
   logic cur_bit, coded_a, coded_b;

   // The output register can take a new bit when empty or being drained this cycle.
   assign slot_free = !enc_valid_q || enc_ready;
   assign emit_step = slot_free && ((state_q == StRun) || (state_q == StTail));
   assign cur_bit   = (state_q == StRun) ? byte_q[bit_idx_q] : 1'b0;
   assign coded_a   = cur_bit ^ s_q[1] ^ s_q[2] ^ s_q[4] ^ s_q[5];
   assign coded_b   = cur_bit ^ s_q[0] ^ s_q[1] ^ s_q[2] ^ s_q[5];
   assign emit_b    = sel_q || !keep_a;
   assign bit_last  = emit_b || !keep_b;
   assign advance   = emit_step && bit_last;
   assign data_last = ((bit_cnt_q + NBITS_W'(1)) == nofbits_q);

`ifdef CONVENC_TAIL_EN
   assign tail_last = (tail_cnt_q == 3'd5);
`else
   assign tail_last = 1'b1;
`endif

   // Every data bit keeps at least one of A/B, so emit_b is always a kept bit.
   always_comb begin
      keep_a      = 1'b1;
      keep_b      = 1'b1;
      period_last = 1'b1;
      unique case (rate_q)
         2'd1: begin
            keep_b      = (phase_q == 2'd0);
            period_last = (phase_q == 2'd1);
         end
         2'd2: begin
            keep_a      = (phase_q != 2'd2);
            keep_b      = (phase_q != 2'd1);
            period_last = (phase_q == 2'd2);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (nofbits == '0) ? StEnd : StLoad;
            end
         end
         StLoad: begin
            if (in_valid) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (advance) begin
               if (data_last) begin
                  state_d = StEnd;
               end else if (bit_idx_q == 3'd7) begin
                  state_d = StLoad;
               end
            end
         end
         StTail: begin
            if (advance && tail_last) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (slot_free) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == StLoad);
      busy      = (state_q != StIdle);
      enc_bit   = enc_bit_q;
      enc_valid = enc_valid_q;
      done      = done_q;
   end

   always_comb begin
      s_d         = s_q;
      byte_d      = byte_q;
      bit_idx_d   = bit_idx_q;
      bit_cnt_d   = bit_cnt_q;
      nofbits_d   = nofbits_q;
      rate_d      = rate_q;
      phase_d     = phase_q;
      sel_d       = sel_q;
      enc_bit_d   = enc_bit_q;
      enc_valid_d = enc_valid_q;
`ifdef CONVENC_TAIL_EN
      tail_cnt_d  = tail_cnt_q;
`endif

      if ((state_q == StIdle) && start) begin
         rate_d    = (coderate == 2'd3) ? 2'd0 : coderate;
         nofbits_d = nofbits;
         bit_cnt_d = '0;
         phase_d   = '0;
         sel_d     = 1'b0;
         s_d       = '0;
`ifdef CONVENC_TAIL_EN
         tail_cnt_d = '0;
`endif
      end

      if ((state_q == StLoad) && in_valid) begin
         byte_d    = in_byte;
         bit_idx_d = '0;
      end

      if (emit_step) begin
         enc_bit_d   = emit_b ? coded_b : coded_a;
         enc_valid_d = 1'b1;
         sel_d       = !bit_last;
         if (advance) begin
            s_d     = {s_q[4:0], cur_bit};
            phase_d = period_last ? 2'd0 : phase_q + 2'd1;
            if (state_q == StRun) begin
               bit_cnt_d = bit_cnt_q + NBITS_W'(1);
               bit_idx_d = bit_idx_q + 3'd1;
            end
`ifdef CONVENC_TAIL_EN
            else begin
               tail_cnt_d = tail_cnt_q + 3'd1;
            end
`endif
         end
      end else if (enc_ready) begin
         enc_valid_d = 1'b0;
      end

      done_d = (state_q == StFlush) && slot_free;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s_q         <= '0;
         byte_q      <= '0;
         bit_idx_q   <= '0;
         bit_cnt_q   <= '0;
         nofbits_q   <= '0;
         rate_q      <= '0;
         phase_q     <= '0;
         sel_q       <= 1'b0;
         enc_bit_q   <= 1'b0;
         enc_valid_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef CONVENC_TAIL_EN
         tail_cnt_q  <= '0;
`endif
      end else begin
         s_q         <= s_d;
         byte_q      <= byte_d;
         bit_idx_q   <= bit_idx_d;
         bit_cnt_q   <= bit_cnt_d;
         nofbits_q   <= nofbits_d;
         rate_q      <= rate_d;
         phase_q     <= phase_d;
         sel_q       <= sel_d;
         enc_bit_q   <= enc_bit_d;
         enc_valid_q <= enc_valid_d;
         done_q      <= done_d;
`ifdef CONVENC_TAIL_EN
         tail_cnt_q  <= tail_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_convenc.sv
// Bench for convenc: randomized frames checked against a generator-polynomial model.
// Honors CONVENC_TAIL_EN the same way as the design.
module tb_convenc;

`ifdef CONVENC_TAIL_EN
   localparam int TailBits = 6;
`else
   localparam int TailBits = 0;
`endif

   logic        clock, reset, start;
   logic [1:0]  coderate;
   logic [14:0] nofbits;
   logic [7:0]  in_byte;
   logic        in_valid, in_ready, enc_bit, enc_valid, enc_ready, busy, done;

   convenc #(.NBITS_W(15)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .coderate  (coderate),
      .nofbits   (nofbits),
      .in_byte   (in_byte),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .enc_bit   (enc_bit),
      .enc_valid (enc_valid),
      .enc_ready (enc_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0] frame_bytes [64];
   logic       got[$];
   logic       exp_q[$];
   logic       ref_q[$];
   int         done_cnt, stall_bad, first_lat;
   logic       timed_out, busy_at_done;

   // Unpunctured stream from the octal generators, then a keep-mask over (A,B) pairs.
   function automatic void build_expected(input logic [1:0] rate, input int nbits);
      logic [6:0] g0, g1, m0, m1, hist;
      logic [7:0] byt;
      logic       b, a, bb;
      int         pat[$];
      g0 = 7'o133;
      g1 = 7'o171;
      hist = '0;
      for (int k = 0; k < 7; k++) begin
         m0[k] = g0[6-k];
         m1[k] = g1[6-k];
      end
      case (rate)
         2'd1:    pat = '{1, 1, 1, 0};
         2'd2:    pat = '{1, 1, 1, 0, 0, 1};
         default: pat = '{1, 1};
      endcase
      exp_q.delete();
      for (int i = 0; i < nbits + TailBits; i++) begin
         if (i < nbits) begin
            byt = frame_bytes[i/8];
            b = byt[i%8];
         end else begin
            b = 1'b0;
         end
         hist = {hist[5:0], b};
         a  = ^(hist & m0);
         bb = ^(hist & m1);
         if (pat[(2*i) % pat.size()] == 1) exp_q.push_back(a);
         if (pat[(2*i+1) % pat.size()] == 1) exp_q.push_back(bb);
      end
   endfunction

   // Drives one frame and records what the DUT emits; no checking here.
   task automatic run_frame(input logic [1:0] rate, input int nbits, input int rdy_pct,
                            input int restart_cyc);
      int   nbytes, bidx, hs_cyc, post;
      logic stalled, held, seen_done;
      nbytes = (nbits + 7) / 8;
      bidx = 0; hs_cyc = -1; post = 0; stalled = 0; held = 0; seen_done = 0;
      got.delete();
      done_cnt = 0; stall_bad = 0; first_lat = -1; timed_out = 0; busy_at_done = 1'b1;
      @(posedge clock); #1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         start     = (cyc == 0) || (cyc == restart_cyc);
         coderate  = (cyc == 0) ? rate : 2'd2;
         nofbits   = (cyc == 0) ? 15'(nbits) : 15'd24;
         in_valid  = (bidx < nbytes);
         in_byte   = (bidx < nbytes) ? frame_bytes[bidx] : 8'h00;
         enc_ready = ($urandom_range(99) < rdy_pct);
         @(negedge clock);
         if (in_valid && in_ready) begin
            if (hs_cyc < 0) hs_cyc = cyc;
            bidx++;
         end
         if (enc_valid && first_lat < 0 && hs_cyc >= 0) first_lat = cyc - hs_cyc;
         if (stalled && (enc_valid !== 1'b1 || enc_bit !== held)) stall_bad++;
         stalled = enc_valid && !enc_ready;
         held = enc_bit;
         if (enc_valid && enc_ready) got.push_back(enc_bit);
         if (done) begin
            done_cnt++;
            busy_at_done = busy;
            seen_done = 1;
         end
         if (seen_done) begin
            if (post == 6) break;
            post++;
         end
         @(posedge clock); #1;
      end
      if (!seen_done) timed_out = 1;
      start = 0; in_valid = 0; enc_ready = 1;
   endtask

   task automatic test_reset;
      int viol;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL por_in_ready got %b want 0", in_ready); end
      n_cmp++; if (enc_valid !== 1'b0) begin n_fail++; $display("FAIL por_enc_valid got %b want 0", enc_valid); end
      n_cmp++; if (enc_bit !== 1'b0) begin n_fail++; $display("FAIL por_enc_bit got %b want 0", enc_bit); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL por_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL por_done got %b want 0", done); end
      @(posedge clock); #1 reset = 0;
      start = 1; coderate = 2'd0; nofbits = 15'd16; in_valid = 1; in_byte = 8'hFF; enc_ready = 1;
      @(posedge clock); #1 start = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (enc_valid) break;
      end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy got %b want 1", busy); end
      @(posedge clock); #1 reset = 1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (enc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_enc_valid got %b want 0", enc_valid); end
      n_cmp++; if (enc_bit !== 1'b0) begin n_fail++; $display("FAIL rst_enc_bit got %b want 0", enc_bit); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      @(posedge clock); #1 reset = 0;
      viol = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (enc_valid || busy || done || in_ready) viol++;
      end
      n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL post_reset_quiet got %0d active cycles want 0", viol); end
      in_valid = 0;
   endtask

   task automatic test_impulse;
      logic [15:0] imp;
      logic        want;
      imp = 16'b1101_1111_0010_1100;
      frame_bytes[0] = 8'h01;
      run_frame(2'd0, 8, 100, -1);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL impulse_timeout got no done want done"); end
      n_cmp++; if (got.size() != 16 + 2*TailBits) begin
         n_fail++; $display("FAIL impulse_len got %0d want %0d", got.size(), 16 + 2*TailBits); end
      for (int i = 0; i < got.size() && i < 16 + 2*TailBits; i++) begin
         want = (i < 16) ? imp[15-i] : 1'b0;
         n_cmp++; if (got[i] !== want) begin
            n_fail++; $display("FAIL impulse_bit %0d got %b want %b", i, got[i], want); end
      end
      n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL impulse_done got %0d want 1", done_cnt); end
      n_cmp++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL impulse_busy_at_done got %b want 0", busy_at_done); end
      n_cmp++; if (first_lat != 2) begin n_fail++; $display("FAIL impulse_latency got %0d want 2", first_lat); end
`ifdef CONVENC_TAIL_EN
      n_cmp++; if (dut.s_q !== 6'd0) begin n_fail++; $display("FAIL tail_final_s got %b want 0", dut.s_q); end
`endif
   endtask

   task automatic test_rate34;
      frame_bytes[0] = 8'hA5; frame_bytes[1] = 8'h3C; frame_bytes[2] = 8'hFF;
      build_expected(2'd2, 24);
      run_frame(2'd2, 24, 100, -1);
      n_cmp++; if (got.size() != ((TailBits != 0) ? 40 : 32)) begin
         n_fail++; $display("FAIL r34_len got %0d want %0d", got.size(), (TailBits != 0) ? 40 : 32); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL r34_bit %0d got %b want %b", i, got[i], exp_q[i]); end
      end
      n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL r34_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_rate23;
      frame_bytes[0] = 8'hA5; frame_bytes[1] = 8'h3C; frame_bytes[2] = 8'hFF;
      build_expected(2'd1, 24);
      run_frame(2'd1, 24, 100, -1);
      n_cmp++; if (got.size() != ((TailBits != 0) ? 45 : 36)) begin
         n_fail++; $display("FAIL r23_len got %0d want %0d", got.size(), (TailBits != 0) ? 45 : 36); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL r23_bit %0d got %b want %b", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure;
      frame_bytes[0] = 8'($urandom); frame_bytes[1] = 8'($urandom);
      build_expected(2'd0, 16);
      run_frame(2'd0, 16, 100, -1);
      ref_q = got;
      run_frame(2'd0, 16, 50, -1);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout got no done want done"); end
      n_cmp++; if (got.size() != ref_q.size()) begin
         n_fail++; $display("FAIL bp_len got %0d want %0d", got.size(), ref_q.size()); end
      for (int i = 0; i < got.size() && i < ref_q.size(); i++) begin
         n_cmp++; if (got[i] !== ref_q[i] || got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL bp_bit %0d got %b want %b", i, got[i], exp_q[i]); end
      end
      n_cmp++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall_hold got %0d changes want 0", stall_bad); end
   endtask

   task automatic test_start_busy;
      frame_bytes[0] = 8'h01;
      build_expected(2'd0, 8);
      run_frame(2'd0, 8, 100, 6);
      n_cmp++; if (got.size() != exp_q.size()) begin
         n_fail++; $display("FAIL busy_start_len got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL busy_start_bit %0d got %b want %b", i, got[i], exp_q[i]); end
      end
      n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_empty;
      build_expected(2'd0, 0);
      run_frame(2'd0, 0, 100, -1);
      n_cmp++; if (got.size() != 2*TailBits) begin
         n_fail++; $display("FAIL empty_len got %0d want %0d", got.size(), 2*TailBits); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL empty_bit %0d got %b want %b", i, got[i], exp_q[i]); end
      end
      n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL empty_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_random;
      logic [1:0] rate;
      int         nbits;
      for (int t = 0; t < 20; t++) begin
         rate  = 2'($urandom_range(3));
         nbits = $urandom_range(60, 1);
         for (int j = 0; j < 8; j++) frame_bytes[j] = 8'($urandom);
         build_expected(rate, nbits);
         run_frame(rate, nbits, $urandom_range(100, 30), -1);
         n_cmp++; if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand%0d_len rate %0d nbits %0d got %0d want %0d",
                               t, rate, nbits, got.size(), exp_q.size()); end
         for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL rand%0d_bit %0d got %b want %b", t, i, got[i], exp_q[i]); end
         end
         n_cmp++; if (done_cnt != 1 || stall_bad != 0) begin
            n_fail++; $display("FAIL rand%0d_ctrl got done %0d stalls %0d want 1 and 0",
                               t, done_cnt, stall_bad); end
      end
   endtask

   initial begin
      clock = 0; reset = 1; start = 0; coderate = 0; nofbits = 0;
      in_byte = 0; in_valid = 0; enc_ready = 1;
      test_reset;
      test_impulse;
      test_rate34;
      test_rate23;
      test_backpressure;
      test_start_busy;
      test_empty;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
